// File: rtl/scan_controller.sv
// scan_controller: VGA scan counters with delayed sync outputs and a double-buffered polygon bank.
// Host writes land in the shadow bank; the active bank reloads from it only at the start of vertical blank.
module scan_controller #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [3:0]  wr_addr,
    input  logic [13:0] wr_data,
    output logic [8:0]  pixel_row,
    output logic [9:0]  pixel_col,
    output logic [1:0]  cmp_en,
    output logic [5:0]  background_color,
    output logic [11:0] poly_color,
    output logic [13:0] v0_x,
    output logic [13:0] v1_x,
    output logic [13:0] v2_x,
    output logic [11:0] v0_y,
    output logic [11:0] v1_y,
    output logic [11:0] v2_y,
    output logic        hsync,
    output logic        vsync,
    output logic        display_en,
    output logic        frame_start,
    output logic        commit_ack
);
    localparam logic [9:0] H_VIS   = 10'(H_VISIBLE);
    localparam logic [9:0] H_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] V_VIS   = 10'(V_VISIBLE);
    localparam logic [9:0] V_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    typedef struct packed {
        logic [13:0] v0_x;
        logic [11:0] v0_y;
        logic [13:0] v1_x;
        logic [11:0] v1_y;
        logic [13:0] v2_x;
        logic [11:0] v2_y;
        logic [11:0] poly_color;
        logic [1:0]  cmp_en;
        logic [5:0]  bg;
    } bank_t;

    logic [1:0] rst_sync_q;
    logic       rst_core_n;
    logic [9:0] h_q, h_d, v_q, v_d;
    logic       h_wrap, swap, hs_n, vs_n, vis;
    logic       hsync_q, vsync_q, de_q, ack_q, ack_d;
    logic       pend_q, pend_d;
    bank_t      shadow_q, shadow_d, active_q, active_d;

    // Reset asserts immediately but releases two clocks later, aligned to clk.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};

    assign rst_core_n = rst_sync_q[1];

    always_comb begin
        h_wrap = h_q == H_LAST;
        h_d    = h_wrap ? 10'd0 : h_q + 10'd1;
        v_d    = !h_wrap ? v_q : (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
        hs_n   = !(h_q >= HS_FIRST && h_q <= HS_LAST);
        vs_n   = !(v_q >= VS_FIRST && v_q <= VS_LAST);
        vis    = h_q < H_VIS && v_q < V_VIS;
        swap   = h_q == 10'd0 && v_q == V_VIS;
    end

    always_comb begin
        pixel_col   = h_q < H_VIS ? h_q : 10'd0;
        pixel_row   = v_q < V_VIS ? v_q[8:0] : 9'd0;
        frame_start = rst_core_n && h_q == 10'd0 && v_q == 10'd0;
    end

    always_comb begin
        shadow_d = shadow_q;
        if (wr_en)
            case (wr_addr)
                4'd0: shadow_d.v0_x = wr_data;
                4'd1: shadow_d.v0_y = wr_data[11:0];
                4'd2: shadow_d.v1_x = wr_data;
                4'd3: shadow_d.v1_y = wr_data[11:0];
                4'd4: shadow_d.v2_x = wr_data;
                4'd5: shadow_d.v2_y = wr_data[11:0];
                4'd6: shadow_d.poly_color = wr_data[11:0];
                4'd7: {shadow_d.cmp_en, shadow_d.bg} = wr_data[7:0];
                default: ;
            endcase
    end

    // The swap sees pre-write shadow and pre-write pending; a commit in the swap cycle re-arms.
    always_comb begin
        ack_d    = swap && pend_q;
        active_d = ack_d ? shadow_q : active_q;
        pend_d   = (pend_q && !swap) || (wr_en && wr_addr == 4'd8);
    end

    always_ff @(posedge clk or negedge rst_core_n)
        if (!rst_core_n) begin
            h_q      <= '0;
            v_q      <= '0;
            hsync_q  <= 1'b1;
            vsync_q  <= 1'b1;
            de_q     <= 1'b0;
            ack_q    <= 1'b0;
            pend_q   <= 1'b0;
            shadow_q <= '0;
            active_q <= '0;
        end else begin
            h_q      <= h_d;
            v_q      <= v_d;
            hsync_q  <= hs_n;
            vsync_q  <= vs_n;
            de_q     <= vis;
            ack_q    <= ack_d;
            pend_q   <= pend_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
        end

    assign hsync            = hsync_q;
    assign vsync            = vsync_q;
    assign display_en       = de_q;
    assign commit_ack       = ack_q;
    assign v0_x             = active_q.v0_x;
    assign v0_y             = active_q.v0_y;
    assign v1_x             = active_q.v1_x;
    assign v1_y             = active_q.v1_y;
    assign v2_x             = active_q.v2_x;
    assign v2_y             = active_q.v2_y;
    assign poly_color       = active_q.poly_color;
    assign cmp_en           = active_q.cmp_en;
    assign background_color = active_q.bg;
endmodule
